io_read_monitor: RTL

Periodic readback sequencer for the FMC151 board monitor's ADC result registers over the monitor SPI bus. Once enabled after monitor initialisation, it sweeps `NUM_CH` consecutive registers. Each register is read with one 32-bit SPI read frame. Results are published as a one-cycle stream beat and also latched into a readable register bank. It shares the monitor SPI pins with the init sequencer through board-level muxing; only one of the two is enabled at a time.

---
 rtl/fmc151_mon_pkg.sv | 34 +++
 rtl/io_spi_frame.sv | 83 ++++++++
 rtl/io_read_monitor.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/fmc151_mon_pkg.sv
// Shared definitions for the FMC151 board-monitor SPI sequencers.
// Latency: n/a (types, constants and a read-command builder only).
// Backpressure: n/a.
package fmc151_mon_pkg;

  // One-hot sequencer states.
  typedef enum logic [4:0] {
    ST_IDLE  = 5'b00001,
    ST_LOAD  = 5'b00010,
    ST_SHIFT = 5'b00100,
    ST_STORE = 5'b01000,
    ST_GAP   = 5'b10000
  } mon_state_e;

  localparam int MON_FRAME_BITS = 32;
  localparam int MON_CMD_BITS   = 16;
  localparam int MON_ADDR_W     = 6;

  // Command word layout: {rd, 3'b000, start_addr[5:0], end_addr[5:0]}.
  localparam int MON_RD_BIT = 15;
  localparam int MON_SA_LSB = 6;
  localparam int MON_EA_LSB = 0;

  // Single-register read: start and end address are the same register.
  function automatic logic [MON_CMD_BITS-1:0] mon_rd_cmd(input logic [MON_ADDR_W-1:0] addr);
    logic [MON_CMD_BITS-1:0] c;
    c = '0;
    c[MON_RD_BIT] = 1'b1;
    c[MON_SA_LSB +: MON_ADDR_W] = addr;
    c[MON_EA_LSB +: MON_ADDR_W] = addr;
    return c;
  endfunction

endpackage

// File: rtl/io_spi_frame.sv
// One SPI mode-0 frame: CS low, lead half-period, WIDTH bits MSB-first, trail half-period.
// Latency: CS low for (2*WIDTH+2)*SCLK_TIME cycles after start; done pulses as CS rises.
// Backpressure: none; start is ignored while a frame is in flight, frames never abort.
// Ports: clk/rst, start (pulse), done (pulse), tx (sampled at start), rx (last WIDTH MISO bits),
//        spi_clk/spi_mosi/spi_cs_n (registered), spi_miso (sampled as spi_clk rises).
module io_spi_frame
  import fmc151_mon_pkg::*;
#(
  parameter int WIDTH     = MON_FRAME_BITS,
  parameter int SCLK_TIME = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             done,
  input  logic [WIDTH-1:0] tx,
  output logic [WIDTH-1:0] rx,
  output logic             spi_clk,
  output logic             spi_mosi,
  input  logic             spi_miso,
  output logic             spi_cs_n
);

  // Half-periods: 0 = lead, odd = bit low phase, even 2..2*WIDTH = bit high phase, last = trail.
  localparam int NHP = 2 * WIDTH + 2;
  localparam int HPW = $clog2(NHP);
  localparam int DW  = $clog2(SCLK_TIME);

  logic             active;
  logic [DW-1:0]    div;
  logic [HPW-1:0]   hp;
  logic [WIDTH-1:0] shreg;  // bits still to be presented after the current one

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      active   <= 1'b0;
      div      <= '0;
      hp       <= '0;
      shreg    <= '0;
      rx       <= '0;
      done     <= 1'b0;
      spi_clk  <= 1'b0;
      spi_mosi <= 1'b0;
      spi_cs_n <= 1'b1;
    end else begin
      done <= 1'b0;
      if (!active) begin
        if (start) begin
          active   <= 1'b1;
          spi_cs_n <= 1'b0;
          div      <= '0;
          hp       <= '0;
          spi_mosi <= tx[WIDTH-1];
          shreg    <= {tx[WIDTH-2:0], 1'b0};
        end
      end else if (div != DW'(SCLK_TIME - 1)) begin
        div <= div + DW'(1);
      end else begin
        div <= '0;
        if (hp == HPW'(NHP - 1)) begin
          active   <= 1'b0;
          spi_cs_n <= 1'b1;
          done     <= 1'b1;
        end else begin
          hp <= hp + HPW'(1);
          if (hp[0]) begin
            // Entering a high phase: the slave has had a full low phase to settle MISO.
            spi_clk <= 1'b1;
            rx      <= {rx[WIDTH-2:0], spi_miso};
          end else begin
            spi_clk <= 1'b0;
            // Lead -> first low phase keeps bit MSB; later low phases (and the trail) advance.
            if (hp != '0) begin
              spi_mosi <= shreg[WIDTH-1];
              shreg    <= {shreg[WIDTH-2:0], 1'b0};
            end
          end
        end
      end
    end
  end

endmodule

// File: rtl/io_read_monitor.sv
// Periodic readback of NUM_CH monitor ADC registers into a bank plus a one-beat stream.
// Latency: per channel 66*SCLK_TIME+3 cycles; data_valid in the STORE cycle, sweep_done one cycle later.
// Backpressure: none; stream beats are fire-and-forget, disabling finishes the current frame first.
// Ports: clk/rst, read_mon_ena (level), mon_busy, sweep_done, data_valid/data_ch/data (stream),
//        rd_addr -> rd_data/rd_valid (combinational bank read), spi_clk/spi_mosi/spi_miso/mon_cs.
module io_read_monitor
  import fmc151_mon_pkg::*;
#(
  parameter int NUM_CH    = 8,
  parameter int SCLK_TIME = 4,
  parameter int POLL_GAP  = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        read_mon_ena,
  output logic        mon_busy,
  output logic        sweep_done,
  output logic        data_valid,
  output logic [5:0]  data_ch,
  output logic [15:0] data,
  input  logic [5:0]  rd_addr,
  output logic [15:0] rd_data,
  output logic        rd_valid,
  output logic        spi_clk,
  output logic        spi_mosi,
  input  logic        spi_miso,
  output logic        mon_cs
);

  localparam int GW = $clog2(POLL_GAP + 1);

  mon_state_e                state, state_nxt;
  logic [5:0]                ch;
  logic [GW-1:0]             gap_cnt;
  logic [15:0]               bank [NUM_CH];
  logic [NUM_CH-1:0]         valid;
  logic                      frame_start, frame_done, last_ch, gap_end;
  logic [MON_FRAME_BITS-1:0] tx_word, rx_word;
  logic                      rx_cmd_unused;

  assign last_ch = (ch == 6'(NUM_CH - 1));
  assign gap_end = (gap_cnt == GW'(POLL_GAP));
  // Command goes out in the first half of the frame; the register value comes back in the second.
  assign tx_word = {mon_rd_cmd(ch), {(MON_FRAME_BITS - MON_CMD_BITS){1'b0}}};
  assign rx_cmd_unused = ^rx_word[MON_FRAME_BITS-1:16];

  io_spi_frame #(
    .WIDTH    (MON_FRAME_BITS),
    .SCLK_TIME(SCLK_TIME)
  ) u_frame (
    .clk     (clk),
    .rst     (rst),
    .start   (frame_start),
    .done    (frame_done),
    .tx      (tx_word),
    .rx      (rx_word),
    .spi_clk (spi_clk),
    .spi_mosi(spi_mosi),
    .spi_miso(spi_miso),
    .spi_cs_n(mon_cs)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (read_mon_ena) state_nxt = ST_LOAD;
      ST_LOAD:  state_nxt = ST_SHIFT;
      ST_SHIFT: if (frame_done) state_nxt = ST_STORE;
      // A completed last channel always closes the sweep; otherwise a low enable stops here.
      ST_STORE: begin
        if (last_ch)           state_nxt = ST_GAP;
        else if (read_mon_ena) state_nxt = ST_LOAD;
        else                   state_nxt = ST_IDLE;
      end
      ST_GAP: begin
        if (!read_mon_ena) state_nxt = ST_IDLE;
        else if (gap_end)  state_nxt = ST_LOAD;
      end
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    frame_start = (state == ST_LOAD);
    mon_busy    = (state != ST_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ch         <= '0;
      gap_cnt    <= '0;
      data_valid <= 1'b0;
      data_ch    <= '0;
      data       <= '0;
      sweep_done <= 1'b0;
      valid      <= '0;
      for (int i = 0; i < NUM_CH; i++) bank[i] <= '0;
    end else begin
      data_valid <= 1'b0;
      sweep_done <= 1'b0;
      case (state)
        ST_IDLE: if (read_mon_ena) ch <= '0;
        // Publish on the edge into STORE so the beat is visible during STORE itself.
        ST_SHIFT: if (frame_done) begin
          data_valid <= 1'b1;
          data_ch    <= ch;
          data       <= rx_word[15:0];
        end
        ST_STORE: begin
          for (int i = 0; i < NUM_CH; i++) begin
            if (ch == 6'(i)) begin
              bank[i]  <= rx_word[15:0];
              valid[i] <= 1'b1;
            end
          end
          if (last_ch) begin
            sweep_done <= 1'b1;
            gap_cnt    <= '0;
          end else if (read_mon_ena) begin
            ch <= ch + 6'd1;
          end
        end
        ST_GAP: begin
          gap_cnt <= gap_cnt + GW'(1);
          if (gap_end) ch <= '0;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    rd_data  = '0;
    rd_valid = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (rd_addr == 6'(i)) begin
        rd_data  = bank[i];
        rd_valid = valid[i];
      end
    end
  end

endmodule
